// File: rtl/fpadd_pkg.sv
// Shared types and constants for the parametrised floating-point adder.
package fpadd_pkg;

    localparam int unsigned DEF_EXP_W  = 8;
    localparam int unsigned DEF_MAN_W  = 23;
    localparam int unsigned W          = 1 + DEF_EXP_W + DEF_MAN_W;
    localparam int unsigned BIAS       = (1 << (DEF_EXP_W - 1)) - 1;
    localparam int unsigned EXP_MAX    = (1 << DEF_EXP_W) - 1;
    localparam int unsigned GRS_W      = 3;
    localparam int unsigned MAX_WORD_W = 128;

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_PACK
    } state_e;

    // Signed infinity for any format; callers truncate to their word width.
    function automatic logic [MAX_WORD_W-1:0] inf_word(input int unsigned exp_w,
                                                       input int unsigned man_w,
                                                       input logic        sgn);
        logic [MAX_WORD_W-1:0] v;
        v = ((MAX_WORD_W'(1) << exp_w) - MAX_WORD_W'(1)) << man_w;
        v = v | (MAX_WORD_W'(sgn) << (exp_w + man_w));
        return v;
    endfunction

    function automatic logic [MAX_WORD_W-1:0] qnan_word(input int unsigned exp_w,
                                                        input int unsigned man_w);
        return inf_word(exp_w, man_w, 1'b0) | (MAX_WORD_W'(1) << (man_w - 1));
    endfunction

endpackage

// File: rtl/fpadd_if.sv
// Start/done handshake and operand/result bus of the floating-point adder.
interface fpadd_if #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
);
    localparam int unsigned WORD_W = 1 + EXP_W + MAN_W;

    logic              start;
    logic              op_sub;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic [WORD_W-1:0] sum;
    logic              done;
    logic              busy;

    modport master (output start, op_sub, a, b, input sum, done, busy);
    modport slave  (input start, op_sub, a, b, output sum, done, busy);
endinterface

// File: rtl/fpadd_round.sv
// Round-to-nearest-even of {hidden, frac, G, R, S}; carry flags mantissa overflow.
module fpadd_round
    import fpadd_pkg::*;
#(
    parameter int unsigned MAN_W = 23
) (
    input  logic [MAN_W+GRS_W:0] i_mant,
    output logic [MAN_W:0]       o_mant_c,
    output logic                 o_carry_c
);
    logic w_inc;

    assign w_inc = i_mant[2] & (i_mant[1] | i_mant[0] | i_mant[3]);
    assign {o_carry_c, o_mant_c} = {1'b0, i_mant[MAN_W+GRS_W:GRS_W]} + (MAN_W+2)'(w_inc);
endmodule

// File: rtl/fpadd_param.sv
// Multi-cycle parametrised FP add/sub with RNE rounding and special-value handling.
// Define FPADD_DENORM_EN to support subnormals; otherwise they are flushed to zero.
module fpadd_param
    import fpadd_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic  clk,
    input  logic  reset,
    fpadd_if.slave bus
);
    localparam int unsigned WORD_W = 1 + EXP_W + MAN_W;
    localparam int unsigned F      = MAN_W + 1 + GRS_W;
    localparam int unsigned XW     = EXP_W + 1;
    localparam logic [XW-1:0]     EXP_ALL1 = XW'((1 << EXP_W) - 1);
    localparam logic [WORD_W-1:0] QNAN     = WORD_W'(qnan_word(EXP_W, MAN_W));
    localparam logic [WORD_W-1:0] PINF     = WORD_W'(inf_word(EXP_W, MAN_W, 1'b0));
`ifdef FPADD_DENORM_EN
    localparam bit DENORM = 1'b1;
`else
    localparam bit DENORM = 1'b0;
`endif

    state_e            r_state;
    logic [WORD_W-1:0] r_a, r_b, r_res, r_sum;
    logic              r_done, r_busy, r_special, r_sx, r_eff_sub;
    logic [XW-1:0]     r_ex, r_ey;
    logic [F-1:0]      r_mx, r_my;
    logic [F:0]        r_mant;

    logic              w_sa, w_sb, w_swap, w_special;
    logic [EXP_W-1:0]  w_ea, w_eb;
    logic [MAN_W-1:0]  w_fa, w_fb;
    logic              w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic [XW-1:0]     w_xa, w_xb, w_diff;
    logic [F-1:0]      w_ma, w_mb, w_mask, w_y_al;
    logic              w_sticky;
    logic [F:0]        w_addsub;
    logic [WORD_W-1:0] w_spec_res, w_pack;
    logic [MAN_W:0]    w_rnd_m;
    logic              w_rnd_c;

    assign bus.sum  = r_sum;
    assign bus.done = r_done;
    assign bus.busy = r_busy;

    // Field split and classification of the captured operands.
    assign {w_sa, w_ea, w_fa} = r_a;
    assign {w_sb, w_eb, w_fb} = r_b;
    assign w_a_zero = (w_ea == '0) && (!DENORM || (w_fa == '0));
    assign w_b_zero = (w_eb == '0) && (!DENORM || (w_fb == '0));
    assign w_a_inf  = (XW'(w_ea) == EXP_ALL1) && (w_fa == '0);
    assign w_b_inf  = (XW'(w_eb) == EXP_ALL1) && (w_fb == '0);
    assign w_a_nan  = (XW'(w_ea) == EXP_ALL1) && (w_fa != '0);
    assign w_b_nan  = (XW'(w_eb) == EXP_ALL1) && (w_fb != '0);
    assign w_xa     = (w_ea == '0) ? XW'(1) : XW'(w_ea);
    assign w_xb     = (w_eb == '0) ? XW'(1) : XW'(w_eb);
    assign w_ma     = {(w_ea != '0), w_fa, GRS_W'(0)};
    assign w_mb     = {(w_eb != '0), w_fb, GRS_W'(0)};
    assign w_swap   = {w_eb, w_fb} > {w_ea, w_fa};
    assign w_special = w_a_nan | w_b_nan | w_a_inf | w_b_inf | w_a_zero | w_b_zero;

    always_comb begin
        w_spec_res = r_a;
        if (w_a_nan || w_b_nan)       w_spec_res = QNAN;
        else if (w_a_inf && w_b_inf)  w_spec_res = (w_sa != w_sb) ? QNAN : {w_sa, PINF[WORD_W-2:0]};
        else if (w_a_inf)             w_spec_res = {w_sa, PINF[WORD_W-2:0]};
        else if (w_b_inf)             w_spec_res = {w_sb, PINF[WORD_W-2:0]};
        else if (w_a_zero && w_b_zero) w_spec_res = {w_sa & w_sb, (WORD_W-1)'(0)};
        else if (w_a_zero)            w_spec_res = r_b;
    end

    // Alignment of the smaller operand; everything past R collapses into S.
    assign w_diff   = r_ex - r_ey;
    assign w_mask   = ~({F{1'b1}} << w_diff);
    assign w_sticky = |(r_my & w_mask);
    assign w_y_al   = (w_diff >= XW'(F - 1)) ? {{(F-1){1'b0}}, |r_my}
                                             : ((r_my >> w_diff) | {{(F-1){1'b0}}, w_sticky});

    assign w_addsub = r_eff_sub ? ({1'b0, r_mx} - {1'b0, r_my}) : ({1'b0, r_mx} + {1'b0, r_my});

    fpadd_round #(.MAN_W(MAN_W)) u_round (
        .i_mant   (r_mant[F-1:0]),
        .o_mant_c (w_rnd_m),
        .o_carry_c(w_rnd_c)
    );

    // Final packing: overflow to infinity, subnormal kept or flushed.
    always_comb begin
        w_pack = {r_sx, r_ex[EXP_W-1:0], r_mant[F-2:GRS_W]};
        if (r_ex >= EXP_ALL1)   w_pack = {r_sx, PINF[WORD_W-2:0]};
        else if (!r_mant[F-1])  w_pack = DENORM ? {r_sx, EXP_W'(0), r_mant[F-2:GRS_W]}
                                                : {r_sx, (WORD_W-1)'(0)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_sum   <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_a     <= bus.a;
                    r_b     <= {bus.b[WORD_W-1] ^ bus.op_sub, bus.b[WORD_W-2:0]};
                    r_busy  <= 1'b1;
                    r_state <= S_UNPACK;
                end
                S_UNPACK: begin
                    r_special <= w_special;
                    r_res     <= w_spec_res;
                    r_sx      <= w_swap ? w_sb : w_sa;
                    r_ex      <= w_swap ? w_xb : w_xa;
                    r_ey      <= w_swap ? w_xa : w_xb;
                    r_mx      <= w_swap ? w_mb : w_ma;
                    r_my      <= w_swap ? w_ma : w_mb;
                    r_eff_sub <= w_sa ^ w_sb;
                    r_state   <= w_special ? S_PACK : S_ALIGN;
                end
                S_ALIGN: begin
                    r_my    <= w_y_al;
                    r_state <= S_ADD;
                end
                S_ADD: begin
                    r_mant  <= w_addsub;
                    r_state <= S_NORM;
                end
                // Leaves for ROUND on the cycle whose shift brings the hidden bit home.
                S_NORM: begin
                    if (r_mant[F]) begin
                        r_mant  <= {1'b0, r_mant[F:2], r_mant[1] | r_mant[0]};
                        r_ex    <= r_ex + XW'(1);
                        r_state <= S_ROUND;
                    end else if (r_mant == '0) begin
                        r_special <= 1'b1;
                        r_res     <= '0;
                        r_state   <= S_PACK;
                    end else if (!r_mant[F-1] && (r_ex > XW'(1))) begin
                        r_mant <= r_mant << 1;
                        r_ex   <= r_ex - XW'(1);
                        if (r_mant[F-2] || (r_ex == XW'(2))) r_state <= S_ROUND;
                    end else begin
                        r_state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    r_mant  <= {1'b0, w_rnd_c | w_rnd_m[MAN_W], w_rnd_m[MAN_W-1:0], GRS_W'(0)};
                    r_ex    <= r_ex + XW'(w_rnd_c);
                    r_state <= S_PACK;
                end
                S_PACK: begin
                    r_sum   <= r_special ? r_res : w_pack;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpadd_param.sv
// Directed single-precision bench for fpadd_param.
module tb_fpadd_param;
    import fpadd_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    logic [W-1:0] res;
    int   lat;
    bit   saw_done;

    localparam logic [W-1:0] ONE  = W'(BIAS) << DEF_MAN_W;
    localparam logic [W-1:0] PINF = W'(EXP_MAX) << DEF_MAN_W;

    fpadd_if #(.EXP_W(DEF_EXP_W), .MAN_W(DEF_MAN_W)) bus ();

    fpadd_param #(.EXP_W(DEF_EXP_W), .MAN_W(DEF_MAN_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, expv);
        end
    endtask

    // Issue one operation and wait (bounded) for done; optional start pokes while busy.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input bit poke,
                          output logic [W-1:0] r, output int l);
        @(negedge clk);
        bus.a = a; bus.b = b; bus.op_sub = sub; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check({tag, "_busy_acc"}, W'(bus.busy), W'(1));
        l = 0;
        while (l < 200) begin
            if (poke && l >= 2 && l < 5) begin
                bus.start = 1'b1; bus.a = 32'h40000000; bus.b = 32'h40000000;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            l++;
            if (bus.done) break;
        end
        bus.start = 1'b0;
        check({tag, "_done_seen"}, W'(bus.done), W'(1));
        check({tag, "_busy_done"}, W'(bus.busy), W'(0));
        r = bus.sum;
    endtask

    initial begin
        reset = 1'b1; bus.start = 1'b0; bus.op_sub = 1'b0; bus.a = '0; bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sum",  bus.sum, W'(0));
        check("rst_done", W'(bus.done), W'(0));
        check("rst_busy", W'(bus.busy), W'(0));
        @(negedge clk); reset = 1'b0;

        run_op("add_1_2", ONE, 32'h40000000, 1'b0, 1'b0, res, lat);
        check("add_1_2", res, 32'h40400000);
        check("add_1_2_lat", W'(lat), W'(6));
        @(posedge clk); #1;
        check("add_1_2_done_pulse", W'(bus.done), W'(0));
        check("add_1_2_busy_after", W'(bus.busy), W'(0));

        run_op("sub_1_1", ONE, ONE, 1'b1, 1'b0, res, lat);
        check("sub_1_1", res, 32'h00000000);
        run_op("tie_odd", 32'h3F800001, 32'h33800000, 1'b0, 1'b0, res, lat);
        check("tie_odd", res, 32'h3F800002);
        check("tie_odd_lat", W'(lat), W'(6));
        run_op("tie_even", ONE, 32'h33800000, 1'b0, 1'b0, res, lat);
        check("tie_even", res, 32'h3F800000);
        run_op("sub_2_1", 32'h40000000, ONE, 1'b1, 1'b0, res, lat);
        check("sub_2_1", res, ONE);
        check("sub_2_1_lat", W'(lat), W'(6));

        run_op("inf_ninf", PINF, 32'hFF800000, 1'b0, 1'b0, res, lat);
        check("inf_ninf", res, 32'h7FC00000);
        check("inf_ninf_lat", W'(lat), W'(2));
        run_op("nan_in", 32'h7F800001, ONE, 1'b0, 1'b0, res, lat);
        check("nan_in", res, 32'h7FC00000);
        run_op("inf_one", ONE, PINF, 1'b0, 1'b0, res, lat);
        check("inf_one", res, PINF);
        run_op("x_plus_nzero", ONE, 32'h80000000, 1'b0, 1'b0, res, lat);
        check("x_plus_nzero", res, ONE);
        check("x_plus_nzero_lat", W'(lat), W'(2));
        run_op("nz_nz", 32'h80000000, 32'h80000000, 1'b0, 1'b0, res, lat);
        check("nz_nz", res, 32'h80000000);
        run_op("pz_sub_pz", 32'h00000000, 32'h00000000, 1'b1, 1'b0, res, lat);
        check("pz_sub_pz", res, 32'h00000000);
        run_op("ovf", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b0, res, lat);
        check("ovf", res, PINF);
        check("ovf_lat", W'(lat), W'(6));

        run_op("cancel", ONE, 32'hBF7FFFFF, 1'b0, 1'b1, res, lat);
        check("cancel", res, 32'h33800000);
        check("cancel_lat", W'(lat), W'(29));
        @(posedge clk); #1;
        check("cancel_done_pulse", W'(bus.done), W'(0));

        // Abort an operation while it is normalising.
        @(negedge clk);
        bus.a = ONE; bus.b = 32'hBF7FFFFF; bus.op_sub = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", W'(bus.busy), W'(0));
        check("abort_done", W'(bus.done), W'(0));
        check("abort_sum",  bus.sum, W'(0));
        @(negedge clk); reset = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) saw_done = 1'b1;
        end
        check("abort_no_done", W'(saw_done), W'(0));

        run_op("subnorm", 32'h00000001, 32'h00000001, 1'b0, 1'b0, res, lat);
`ifdef FPADD_DENORM_EN
        check("subnorm", res, 32'h00000002);
`else
        check("subnorm", res, 32'h00000000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fpadd_param.md
Name: fpadd_param

Overview:
- Parametrised multi-cycle IEEE-754-style floating-point adder/subtractor; next generation of the team's single-precision FSM adder.
- Configurable exponent/mantissa widths, runtime add/sub select, correct alignment with guard/round/sticky, round-to-nearest-even, and full special-value handling.
- Sits in the arithmetic datapath behind a start/done handshake; one operation in flight.

Parameters:
- EXP_W, 8, exponent field width (>=3)
- MAN_W, 23, stored fraction width (>=2); total word W = 1+EXP_W+MAN_W

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; same-edge effect
- start  in  1  launch request; a, b, op_sub sampled on the edge start=1 and busy=0
- op_sub  in  1  1: compute a-b (b sign inverted at sample)
- a  in  W  operand A
- b  in  W  operand B
- sum  out  W  result; registered; held until next accepted start
- done  out  1  one-cycle pulse, coincident with new sum
- busy  out  1  high from accepting edge until the edge done rises; start ignored while busy

Behaviour:
- Reset: state IDLE, sum=0, done=0, busy=0; reset mid-operation aborts the operation, no done.
- States: IDLE -> UNPACK -> (special ? PACK : ALIGN) -> ADD -> NORM -> ROUND -> PACK -> IDLE.
- UNPACK: split fields, insert hidden bit (1 if exp!=0), classify zero/inf/NaN; compare |a|,|b| by {exp,frac}; swap so larger magnitude is operand X.
- Specials, resolved in UNPACK, result in PACK: any NaN -> canonical qNaN {0, all-ones exp, 1 followed by zeros}; inf + -inf (effective) -> qNaN; single inf -> that inf; x+0 -> x; +0 + -0 -> +0; -0 + -0 -> -0.
- ALIGN: shift Y right by expX-expY in one cycle into MAN_W+4-bit field (hidden, frac, G, R, S); bits shifted past R OR into S; shift >= MAN_W+3 leaves Y = sticky only.
- ADD: effective sign = signX ^ signY; add or subtract (X-Y, never negative); result sign = signX; width MAN_W+5 for carry.
- NORM: carry-out -> shift right 1 (LSB ORed into S), exp+1, one cycle; else shift left 1 bit per cycle while hidden bit 0 and exp>1, exp-1 per shift. Exact zero -> +0, skip to PACK.
- ROUND: RNE on G,R,S; increment on G&(R|S|lsb); mantissa overflow -> exp+1, frac=0.
- Overflow: exp reaching all-ones -> signed inf.
- Latency, accept edge N: specials done at N+2; normal path done at N+5+k, k = NORM cycles (1..MAN_W+3). busy deasserts at the done edge; start on that same cycle is accepted.

Optional Feature:
- FPADD_DENORM_EN defined: subnormal inputs used with hidden bit 0 and effective exp 1; NORM stops at exp=1 yielding subnormal output (exp field 0).
- Undefined: subnormal inputs flushed to signed zero in UNPACK; results below min normal flushed to signed zero (sign of result) in PACK.

Decomposition:
- Package fpadd_pkg: state enum, localparams W, BIAS, EXP_MAX, GRS width, qNaN/inf constant functions parametrised on EXP_W/MAN_W.
- Sub-module fpadd_round: combinational RNE (mantissa+GRS in -> rounded mantissa, carry out); instantiated once in ROUND.

Test Plan (EXP_W=8, MAN_W=23):
- a=0x3F800000, b=0x40000000, op_sub=0 -> sum=0x40400000, done one pulse, busy low after.
- a=0x3F800000, b=0x3F800000, op_sub=1 -> sum=0x00000000 (+0).
- a=0x3F800001, b=0x33800000 (tie, odd lsb) -> 0x3F800002; a=0x3F800000, same b -> 0x3F800000.
- a=0x7F800000, b=0xFF800000 -> 0x7FC00000; a=0x7F7FFFFF, b=0x7F7FFFFF -> 0x7F800000.
- a=0x3F800000, b=0xBF7FFFFF (massive cancellation) -> 0x33800000, done at N+5+24; start pulses while busy ignored.
- reset asserted mid-NORM -> next edge busy=0, done=0, sum=0; then a=0x00000001, b=0x00000001 -> 0x00000002 with FPADD_DENORM_EN, 0x00000000 without.
